// File: rtl/fetch_pc_predictor_pkg.sv
// fetch_pc_predictor_pkg: shared constants, BTB entry type and index/tag/counter helpers
package fetch_pc_predictor_pkg;
  localparam int PC_WIDTH = 32;
  typedef enum logic [1:0] {SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11} ctr_e;
  // tag and target are held at full PC_WIDTH; only the meaningful tag bits are ever non-zero
  typedef struct packed {
    logic                valid;
    logic [PC_WIDTH-1:0] tag;
    logic [PC_WIDTH-1:0] target;
    ctr_e                ctr;
  } btb_entry_t;
  function automatic logic [PC_WIDTH-1:0] btb_index(input logic [PC_WIDTH-1:0] pc, input int off, input int idx);
    return (pc >> off) & ((PC_WIDTH'(1) << idx) - PC_WIDTH'(1));
  endfunction
  function automatic logic [PC_WIDTH-1:0] btb_tag(input logic [PC_WIDTH-1:0] pc, input int off, input int idx);
    return pc >> (off + idx);
  endfunction
  // saturating 2-bit counter: SNT and ST are sticky
  function automatic ctr_e ctr_next(input ctr_e c, input logic taken);
    return taken ? ((c == ST) ? ST : ctr_e'(c + 2'd1)) : ((c == SNT) ? SNT : ctr_e'(c - 2'd1));
  endfunction
endpackage

// File: rtl/fetch_pc_predictor_btb.sv
// fetch_pc_predictor_btb: direct-mapped BTB with one combinational read port and one registered update port
//   i_rd_pc -> o_taken/o_target : lookup for the current fetch PC (pre-update contents, no bypass)
//   i_upd_*                     : training from execute-stage branch resolution
module fetch_pc_predictor_btb
  import fetch_pc_predictor_pkg::*;
#(
  parameter int WIDTH   = PC_WIDTH,
  parameter int ENTRIES = 16,
  parameter int OFF     = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_rd_pc,
  output logic             o_taken,
  output logic [WIDTH-1:0] o_target,
  input  logic             i_upd_valid,
  input  logic [WIDTH-1:0] i_upd_pc,
  input  logic [WIDTH-1:0] i_upd_target,
  input  logic             i_upd_taken
);
  localparam int IDX = $clog2(ENTRIES);
  btb_entry_t mem [ENTRIES];
  logic [IDX-1:0]      rd_idx, upd_idx;
  logic [PC_WIDTH-1:0] rd_tag, upd_tag;
  logic                rd_hit, upd_hit;
  assign rd_idx   = IDX'(btb_index(PC_WIDTH'(i_rd_pc), OFF, IDX));
  assign rd_tag   = btb_tag(PC_WIDTH'(i_rd_pc), OFF, IDX);
  assign upd_idx  = IDX'(btb_index(PC_WIDTH'(i_upd_pc), OFF, IDX));
  assign upd_tag  = btb_tag(PC_WIDTH'(i_upd_pc), OFF, IDX);
  assign rd_hit   = mem[rd_idx].valid && (mem[rd_idx].tag == rd_tag);
  assign upd_hit  = mem[upd_idx].valid && (mem[upd_idx].tag == upd_tag);
  assign o_taken  = rd_hit && mem[rd_idx].ctr[1];
  assign o_target = WIDTH'(mem[rd_idx].target);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};
    end else if (i_upd_valid) begin
      if (upd_hit) begin
        mem[upd_idx].ctr <= ctr_next(mem[upd_idx].ctr, i_upd_taken);
        if (i_upd_taken) mem[upd_idx].target <= PC_WIDTH'(i_upd_target);
      end else if (i_upd_taken) begin
        // taken miss allocates, evicting whatever aliased into this slot
        mem[upd_idx] <= '{valid: 1'b1, tag: upd_tag, target: PC_WIDTH'(i_upd_target), ctr: WT};
      end
    end
  end
endmodule

// File: rtl/fetch_pc_predictor.sv
// fetch_pc_predictor: fetch PC register plus BTB-based next-PC prediction, redirected by execute
//   i_stall holds the PC; i_mispredict loads i_redirect_pc (beats stall) and pulses o_flush next cycle
//   o_pc/o_ppc/o_pred_taken: current fetch PC, its predicted successor, and whether that is a taken prediction
//   i_upd_*: branch resolution used to train the BTB (not blocked by stall)
//   FETCH_PRED_STATS_EN adds saturating o_lookup_cnt / o_mispred_cnt counters
module fetch_pc_predictor
  import fetch_pc_predictor_pkg::*;
#(
  parameter int               WIDTH       = PC_WIDTH,
  parameter int               BTB_ENTRIES = 16,
  parameter int               PC_STEP     = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_upd_valid,
  input  logic [WIDTH-1:0] i_upd_pc,
  input  logic [WIDTH-1:0] i_upd_target,
  input  logic             i_upd_taken,
  input  logic             i_mispredict,
  input  logic [WIDTH-1:0] i_redirect_pc,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_ppc,
  output logic             o_pred_taken,
`ifdef FETCH_PRED_STATS_EN
  output logic [31:0]      o_lookup_cnt,
  output logic [31:0]      o_mispred_cnt,
`endif
  output logic             o_flush
);
  logic [WIDTH-1:0] btb_target;
  fetch_pc_predictor_btb #(
    .WIDTH   (WIDTH),
    .ENTRIES (BTB_ENTRIES),
    .OFF     ($clog2(PC_STEP))
  ) u_btb (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_rd_pc      (o_pc),
    .o_taken      (o_pred_taken),
    .o_target     (btb_target),
    .i_upd_valid  (i_upd_valid),
    .i_upd_pc     (i_upd_pc),
    .i_upd_target (i_upd_target),
    .i_upd_taken  (i_upd_taken)
  );
  // sequential successor wraps modulo 2^WIDTH
  assign o_ppc = o_pred_taken ? btb_target : o_pc + WIDTH'(PC_STEP);
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_pc    <= RESET_PC;
      o_flush <= 1'b0;
    end else begin
      o_pc    <= i_mispredict ? i_redirect_pc : i_stall ? o_pc : o_ppc;
      o_flush <= i_mispredict;
    end
  end
`ifdef FETCH_PRED_STATS_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_lookup_cnt  <= '0;
      o_mispred_cnt <= '0;
    end else begin
      if (!i_mispredict && !i_stall && o_lookup_cnt != '1) o_lookup_cnt <= o_lookup_cnt + 32'd1;
      if (i_mispredict && o_mispred_cnt != '1) o_mispred_cnt <= o_mispred_cnt + 32'd1;
    end
  end
`endif
endmodule
